// File: rtl/trace_pkg.sv
// Shared types and encodings for the trace capture block.
package trace_pkg;

  typedef enum logic [1:0] {
    TS_IDLE    = 2'd0,
    TS_ARMED   = 2'd1,
    TS_CAPTURE = 2'd2,
    TS_DONE    = 2'd3
  } trace_state_t;

  localparam logic [1:0] MODE_EVERY  = 2'b00;
  localparam logic [1:0] MODE_CHANGE = 2'b01;
  localparam logic [1:0] MODE_TRIG   = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  // The reserved encoding behaves exactly like every-cycle capture.
  function automatic logic [1:0] eff_mode(input logic [1:0] m);
    return (m == MODE_RSVD) ? MODE_EVERY : m;
  endfunction

endpackage

// File: rtl/trace_capture_if.sv
// Control, monitored-data and read-port bundle for trace_capture.
interface trace_capture_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 32
);
  localparam int TCW = $clog2(CHANNELS);
  localparam int CW  = $clog2(DEPTH) + 1;

  logic                      arm;
  logic                      abort;
  logic [1:0]                mode;
  logic                      wrap;
  logic [TCW-1:0]            trig_chan;
  logic [WIDTH-1:0]          trig_value;
  logic [CHANNELS*WIDTH-1:0] chan_in;
  logic                      rd_ready;
  logic                      rd_valid;
  logic [CHANNELS*WIDTH-1:0] rd_data;
  logic [CW-1:0]             count;
  logic [1:0]                state;
  logic                      overflow;

  modport master (
    output arm, abort, mode, wrap, trig_chan, trig_value, chan_in, rd_ready,
    input  rd_valid, rd_data, count, state, overflow
  );

  modport slave (
    input  arm, abort, mode, wrap, trig_chan, trig_value, chan_in, rd_ready,
    output rd_valid, rd_data, count, state, overflow
  );
endinterface

// File: rtl/trace_fifo.sv
// Trace storage: circular buffer with push/pop and optional overwrite-oldest when full.
module trace_fifo #(
  parameter int DW    = 64,
  parameter int DEPTH = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_overwrite,
  input  logic [DW-1:0]            i_wr_data,
  output logic [DW-1:0]            o_rd_data,
  output logic                     o_rd_valid,
  output logic                     o_full,
  output logic                     o_overwrote,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_ovw;

  assign w_full = (r_count == CW'(DEPTH));
  assign w_pop  = i_pop && (r_count != '0);
  // A coinciding pop makes room, so only an unmatched push into a full buffer overwrites.
  assign w_ovw  = i_push && w_full && !w_pop && i_overwrite;
  assign w_push = i_push && (!w_full || w_pop || i_overwrite);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop || w_ovw)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_ovw && !w_pop)
        r_count <= r_count + CW'(1);
      else if (w_pop && !w_push)
        r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_rst && !i_clr)
      r_mem[r_wr_ptr] <= i_wr_data;
  end

  assign o_rd_valid  = (r_count != '0);
  assign o_rd_data   = o_rd_valid ? r_mem[r_rd_ptr] : '0;
  assign o_full      = w_full;
  assign o_overwrote = w_ovw;
  assign o_count     = r_count;

endmodule

// File: rtl/trace_capture.sv
// Trace capture controller: qualifies chan_in samples and feeds them into trace_fifo.
//   state    | meaning
//   IDLE     | no session since reset
//   ARMED    | buffer cleared, waiting to start (trigger in mode 10)
//   CAPTURE  | storing qualified samples
//   DONE     | session ended by abort or full buffer without wrap
module trace_capture
  import trace_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 32
) (
  input logic            i_clk,
  input logic            i_rst,
  trace_capture_if.slave bus
);
  localparam int TCW = $clog2(CHANNELS);
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int DW  = CHANNELS * WIDTH;

  localparam logic [1:0] S_IDLE    = TS_IDLE;
  localparam logic [1:0] S_ARMED   = TS_ARMED;
  localparam logic [1:0] S_CAPTURE = TS_CAPTURE;
  localparam logic [1:0] S_DONE    = TS_DONE;

  logic [1:0]       r_state;
  logic             r_overflow;
  logic [WIDTH-1:0] r_prev_ch0;

  logic [1:0]       w_state_nxt;
  logic [1:0]       w_mode;
  logic             w_clr;
  logic             w_cap_win;
  logic             w_event;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_stop_full;
  logic             w_ovf_set;
  logic             w_trig_hit;
  logic             w_overwrote;
  logic             w_rd_valid;
  logic [WIDTH-1:0] w_ch0;
  logic [WIDTH-1:0] w_trig_sel;
  logic [CW-1:0]    w_count;
  logic [DW-1:0]    w_rd_data;

  assign w_mode = eff_mode(bus.mode);
  assign w_ch0  = bus.chan_in[WIDTH-1:0];

  always_comb begin
    w_trig_sel = '0;
    for (int k = 0; k < CHANNELS; k++)
      if (bus.trig_chan == TCW'(k))
        w_trig_sel = bus.chan_in[k*WIDTH +: WIDTH];
  end

  assign w_trig_hit  = (w_trig_sel == bus.trig_value);
  assign w_stop_full = w_full && !bus.wrap;

  // arm restarts a session from any state and beats abort.
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_cap_win   = 1'b0;
    if (bus.arm) begin
      w_state_nxt = S_ARMED;
      w_clr       = 1'b1;
    end else begin
      case (r_state)
        S_ARMED: begin
          if (bus.abort)
            w_state_nxt = S_DONE;
          else if (w_mode != MODE_TRIG || w_trig_hit) begin
            w_state_nxt = S_CAPTURE;
            w_cap_win   = 1'b1;
          end
        end
        S_CAPTURE: begin
          if (bus.abort || w_stop_full)
            w_state_nxt = S_DONE;
          w_cap_win = !bus.abort;
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // The transition cycle out of ARMED is the first capture cycle, so it always qualifies.
  assign w_event = w_cap_win &&
                   ((w_mode != MODE_CHANGE) || (r_state == S_ARMED) || (w_ch0 != r_prev_ch0));

  assign w_pop     = bus.rd_ready && w_rd_valid;
  assign w_push    = w_event && !w_stop_full;
  assign w_ovf_set = (w_event && w_stop_full) || w_overwrote;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_overflow <= 1'b0;
      r_prev_ch0 <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_prev_ch0 <= w_ch0;
      if (w_clr)
        r_overflow <= 1'b0;
      else if (w_ovf_set)
        r_overflow <= 1'b1;
    end
  end

  trace_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clr       (w_clr),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_overwrite (bus.wrap),
    .i_wr_data   (bus.chan_in),
    .o_rd_data   (w_rd_data),
    .o_rd_valid  (w_rd_valid),
    .o_full      (w_full),
    .o_overwrote (w_overwrote),
    .o_count     (w_count)
  );

  assign bus.rd_valid = w_rd_valid;
  assign bus.rd_data  = w_rd_data;
  assign bus.count    = w_count;
  assign bus.state    = r_state;
  assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture with a 4-entry buffer and four 16-bit channels.
module tb_trace_capture;
  localparam int WIDTH    = 16;
  localparam int CHANNELS = 4;
  localparam int DEPTH    = 4;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  trace_capture_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH)) bus ();

  trace_capture #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ch(input logic [15:0] c0, input logic [15:0] c3);
    return {c3, 16'h0, 16'h0, c0};
  endfunction

  initial begin
    rst            = 1'b1;
    bus.arm        = 1'b0;
    bus.abort      = 1'b0;
    bus.mode       = 2'b00;
    bus.wrap       = 1'b0;
    bus.trig_chan  = '0;
    bus.trig_value = '0;
    bus.chan_in    = '0;
    bus.rd_ready   = 1'b0;
    tick();
    tick();
    check_val("rst_state", 64'(bus.state), 64'd0);
    check_val("rst_count", 64'(bus.count), 64'd0);
    check_val("rst_valid", 64'(bus.rd_valid), 64'd0);
    check_val("rst_ovf", 64'(bus.overflow), 64'd0);
    check_val("rst_data", bus.rd_data, 64'd0);
    bus.arm = 1'b1;
    tick();
    check_val("arm_in_rst", 64'(bus.state), 64'd0);
    bus.arm = 1'b0;
    rst     = 1'b0;
    tick();

    // mode 00, stop when full
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    check_val("m0_armed", 64'(bus.state), 64'd1);
    for (int v = 1; v <= 6; v++) begin
      bus.chan_in = ch(16'(v), 16'h0);
      tick();
      if (v == 1) begin
        check_val("m0_cap_state", 64'(bus.state), 64'd2);
        check_val("m0_first_valid", 64'(bus.rd_valid), 64'd1);
        check_val("m0_first_data", bus.rd_data, ch(16'd1, 16'h0));
      end
      if (v == 4) begin
        check_val("m0_full_count", 64'(bus.count), 64'd4);
        check_val("m0_full_ovf", 64'(bus.overflow), 64'd0);
      end
      if (v == 5) begin
        check_val("m0_done", 64'(bus.state), 64'd3);
        check_val("m0_ovf", 64'(bus.overflow), 64'd1);
      end
    end
    check_val("m0_count_hold", 64'(bus.count), 64'd4);
    tick();
    check_val("m0_hold_data", bus.rd_data, ch(16'd1, 16'h0));
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_val("m0_read", bus.rd_data, ch(16'(i + 1), 16'h0));
      tick();
    end
    bus.rd_ready = 1'b0;
    check_val("m0_empty_valid", 64'(bus.rd_valid), 64'd0);
    check_val("m0_empty_count", 64'(bus.count), 64'd0);

    // mode 01, change of channel 0
    bus.mode = 2'b01;
    bus.arm  = 1'b1;
    tick();
    bus.arm = 1'b0;
    check_val("m1_armed", 64'(bus.state), 64'd1);
    check_val("m1_ovf_clr", 64'(bus.overflow), 64'd0);
    begin
      logic [15:0] seq [6];
      seq = '{16'd5, 16'd5, 16'd6, 16'd6, 16'd6, 16'd7};
      for (int i = 0; i < 6; i++) begin
        bus.chan_in = ch(seq[i], 16'h0);
        tick();
      end
    end
    check_val("m1_count", 64'(bus.count), 64'd3);
    check_val("m1_state", 64'(bus.state), 64'd2);
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_val("m1_read", bus.rd_data, ch(16'(5 + i), 16'h0));
      tick();
    end
    bus.rd_ready = 1'b0;
    check_val("m1_drained", 64'(bus.count), 64'd0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_val("m1_abort", 64'(bus.state), 64'd3);

    // mode 10, trigger on IR (channel 3); a decoy match on channel 2 must not fire
    bus.mode       = 2'b10;
    bus.trig_chan  = 2'd3;
    bus.trig_value = 16'h1234;
    bus.arm        = 1'b1;
    tick();
    bus.arm = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      bus.chan_in = {(c == 7) ? 16'h1234 : 16'(c), (c == 3) ? 16'h1234 : 16'h0, 16'h0, 16'(c)};
      tick();
      if (c < 7)
        check_val("m2_wait", 64'(bus.state), 64'd1);
      if (c == 7) begin
        check_val("m2_trig_state", 64'(bus.state), 64'd2);
        check_val("m2_trig_count", 64'(bus.count), 64'd1);
        check_val("m2_first", bus.rd_data, {16'h1234, 32'h0, 16'd7});
      end
    end
    check_val("m2_count", 64'(bus.count), 64'd3);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_val("m2_abort", 64'(bus.state), 64'd3);

    // wrap mode overwrite of oldest
    bus.mode = 2'b00;
    bus.wrap = 1'b1;
    bus.arm  = 1'b1;
    tick();
    bus.arm = 1'b0;
    for (int v = 1; v <= 6; v++) begin
      bus.chan_in = ch(16'(v), 16'h0);
      tick();
      if (v == 4)
        check_val("wr_ovf_pre", 64'(bus.overflow), 64'd0);
    end
    check_val("wr_count", 64'(bus.count), 64'd4);
    check_val("wr_ovf", 64'(bus.overflow), 64'd1);
    check_val("wr_state", 64'(bus.state), 64'd2);
    bus.abort = 1'b1;
    tick();
    bus.abort    = 1'b0;
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_val("wr_read", bus.rd_data, ch(16'(3 + i), 16'h0));
      tick();
    end
    bus.rd_ready = 1'b0;

    // full with simultaneous push and pop
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    for (int v = 1; v <= 4; v++) begin
      bus.chan_in = ch(16'(v), 16'h0);
      tick();
    end
    check_val("pp_full", 64'(bus.count), 64'd4);
    bus.chan_in  = ch(16'd5, 16'h0);
    bus.rd_ready = 1'b1;
    check_val("pp_head", bus.rd_data, ch(16'd1, 16'h0));
    tick();
    bus.rd_ready = 1'b0;
    check_val("pp_count", 64'(bus.count), 64'd4);
    check_val("pp_ovf", 64'(bus.overflow), 64'd0);
    bus.abort   = 1'b1;
    bus.chan_in = ch(16'd6, 16'h0);
    tick();
    bus.abort    = 1'b0;
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_val("pp_read", bus.rd_data, ch(16'(2 + i), 16'h0));
      tick();
    end
    bus.rd_ready = 1'b0;

    // arm beats abort; push and pop while empty
    bus.wrap  = 1'b0;
    bus.arm   = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.arm   = 1'b0;
    bus.abort = 1'b0;
    check_val("prio_state", 64'(bus.state), 64'd1);
    bus.rd_ready = 1'b1;
    bus.chan_in  = ch(16'd10, 16'h0);
    tick();
    check_val("ep_count", 64'(bus.count), 64'd1);
    check_val("ep_data", bus.rd_data, ch(16'd10, 16'h0));
    bus.chan_in = ch(16'd11, 16'h0);
    tick();
    check_val("ep_count2", 64'(bus.count), 64'd1);
    check_val("ep_data2", bus.rd_data, ch(16'd11, 16'h0));
    bus.rd_ready = 1'b0;

    // reset mid-capture
    for (int v = 12; v <= 13; v++) begin
      bus.chan_in = ch(16'(v), 16'h0);
      tick();
    end
    check_val("mr_count", 64'(bus.count), 64'd3);
    check_val("mr_state", 64'(bus.state), 64'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("mr_rst_state", 64'(bus.state), 64'd0);
    check_val("mr_rst_count", 64'(bus.count), 64'd0);
    check_val("mr_rst_valid", 64'(bus.rd_valid), 64'd0);
    check_val("mr_rst_data", bus.rd_data, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
